period_meter: RTL and testbench
===============================

Name: period_meter

Overview:
- Measures the spacing of a tick stream: the number of enabled clock cycles between consecutive qualified ticks.
- It is the receiving end of our programmable down-counter tick generator. A generator loaded with N and running continuously produces ticks N enabled cycles apart, and this block reports N.
- Used for self-check of prescalers and for measuring external strobe rates. Results go to a consumer through a valid/ack register.

Parameters:
WORDSIZE  8  width of the period counter and result; maximum reportable period is 2^WORDSIZE-1

Ports:
iClk  input  1  system clock, rising edge
iReset  input  1  asynchronous reset, active-high
iStart  input  1  arm request; honoured only in IDLE
iStop  input  1  abort; any state goes to IDLE
iContinuous  input  1  1 = keep measuring after each capture; 0 = single shot
iEnable  input  1  count strobe; cycles with iEnable=0 are neither counted nor tick-qualified
iTick  input  1  event input; a tick is qualified only when iTick=1 and iEnable=1
iAck  input  1  consumer acknowledges the current result
oPeriod  output  WORDSIZE  last captured period
oValid  output  1  result pending, held until acknowledged
oOverflow  output  1  last result saturated (period >= 2^WORDSIZE)
oLost  output  1  a result was overwritten before being acknowledged
oBusy  output  1  state != IDLE

Behaviour:
- Clock and reset: one clock, iClk. Reset iReset is asynchronous and active-high.
- Reset values: state=IDLE, rCount=0, oPeriod=0, oValid=0, oOverflow=0, oLost=0, oBusy=0.
- Reset mid-operation: asserting reset in any state forces these values immediately, without waiting for a clock edge.
- "qtick" below means a qualified tick (iTick & iEnable).
- State IDLE:
  - iStart=1 and iStop=0 -> ARMED.
- State ARMED:
  - Waits for the first qtick.
  - On qtick: rCount<=0, -> MEASURE.
- State MEASURE, on a cycle with iEnable=1:
  - Not a qtick and rCount < max: rCount<=rCount+1.
  - qtick and rCount < max: capture. oPeriod<=rCount+1, oOverflow<=0.
  - rCount == max (all ones) and iEnable=1, with or without qtick: overflow capture. oPeriod<=all ones, oOverflow<=1.
- State MEASURE, on a cycle with iEnable=0: no change.
- After a normal capture:
  - iContinuous=1: rCount<=0, stay in MEASURE (the capture tick is also the arming tick of the next period).
  - iContinuous=0: -> IDLE.
- After an overflow capture:
  - iContinuous=1: -> ARMED.
  - iContinuous=0: -> IDLE.
- Latency and period arithmetic:
  - The result is registered and appears the cycle after the capture edge.
  - Qticks exactly N enabled cycles apart give oPeriod=N for 1 <= N <= 2^WORDSIZE-1.
  - N=1 (qtick on every enabled cycle) gives oPeriod=1.
  - A generator loaded with 0 (period 2^WORDSIZE) gives oOverflow=1.
- Valid/ack handshake:
  - Every capture sets oValid<=1.
  - iAck with no capture that cycle clears oValid and oLost.
  - iAck in the same cycle as a capture: the capture wins, so oValid stays 1 and oLost<=0.
  - A capture while oValid=1 and iAck=0 overwrites oPeriod/oOverflow and sets oLost<=1.
  - iAck while oValid=0 has no effect.
- iStop:
  - From any state -> IDLE next edge, rCount<=0.
  - Does not touch oValid, oPeriod, oOverflow or oLost.
  - A qtick in the same cycle as iStop is not captured.
- Simultaneous requests:
  - iStart and iStop together: iStop wins.
  - iStart outside IDLE is ignored.
  - Changing iContinuous mid-measurement takes effect at the next capture.
- oBusy is combinational from state.

Test Plan:
- Single shot, WORDSIZE=8, iEnable=1, qticks every 5 cycles, pulse iStart -> one cycle after the 2nd tick: oPeriod=5, oValid=1, oOverflow=0, oBusy=0; later ticks are ignored.
- iEnable toggling 1,0,1,0..., iTick asserted every 8 raw cycles aligned to iEnable=1, plus stray iTick pulses with iEnable=0 -> oPeriod=4; the stray ticks have no effect.
- Continuous, period 3, iAck held 0 -> 2nd capture gives oPeriod=3, oLost=1; one iAck pulse -> oValid=0, oLost=0; 3rd capture -> oValid=1, oLost=0. Repeat with iAck coincident with a capture -> oValid stays 1.
- WORDSIZE=4, period 15 -> oPeriod=15, oOverflow=0. Period 16 -> oPeriod=15, oOverflow=1; in continuous mode the next normal period is reported correctly after re-arm.
- Period 1 (iTick=iEnable=1 every cycle), continuous -> oPeriod=1 every cycle and oValid stays 1.
- Reset asserted asynchronously mid-MEASURE with oValid=1 -> all outputs 0 before the next clock edge, state IDLE. iStop mid-MEASURE -> oBusy=0 with oPeriod/oValid retained. iStart+iStop together in IDLE -> stays IDLE.

Source files
------------

// File: rtl/period_meter.sv
// period_meter: measures the number of enabled clock cycles between
// consecutive qualified ticks (iTick & iEnable) and hands each result to a
// consumer through a valid/ack register.
//
// Result handshake: every capture loads oPeriod/oOverflow and raises oValid,
// which stays high until the consumer pulses iAck on a cycle without a
// capture. If a capture coincides with iAck, the new result wins: oValid
// stays high and oLost is cleared. A capture that lands while oValid is still
// high and unacknowledged overwrites the result and raises oLost.
module period_meter #(
    parameter int WORDSIZE = 8
) (
    input  logic                iClk,
    input  logic                iReset,
    input  logic                iStart,
    input  logic                iStop,
    input  logic                iContinuous,
    input  logic                iEnable,
    input  logic                iTick,
    input  logic                iAck,
    output logic [WORDSIZE-1:0] oPeriod,
    output logic                oValid,
    output logic                oOverflow,
    output logic                oLost,
    output logic                oBusy
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ARMED   = 2'd1;
    localparam logic [1:0] MEASURE = 2'd2;

    localparam logic [WORDSIZE-1:0] ZERO     = '0;
    localparam logic [WORDSIZE-1:0] ONE      = {{(WORDSIZE-1){1'b0}}, 1'b1};
    localparam logic [WORDSIZE-1:0] ALL_ONES = '1;

    logic [1:0]          rState;
    logic [WORDSIZE-1:0] rCount;

    logic qTick;
    logic countFull;
    logic measureCycle;
    logic normalCapture;
    logic overflowCapture;
    logic capture;

    // A stop in the same cycle suppresses any capture; disabled cycles are frozen.
    assign qTick           = iTick & iEnable;
    assign countFull       = (rCount == ALL_ONES);
    assign measureCycle    = (rState == MEASURE) && !iStop && iEnable;
    assign overflowCapture = measureCycle && countFull;
    assign normalCapture   = measureCycle && qTick && !countFull;
    assign capture         = normalCapture || overflowCapture;

    assign oBusy = (rState != IDLE);

    // Sequencing of idle / armed / measuring and the enabled-cycle counter.
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            rState <= IDLE;
            rCount <= ZERO;
        end else if (iStop) begin
            rState <= IDLE;
            rCount <= ZERO;
        end else begin
            case (rState)
                IDLE: begin
                    if (iStart) begin
                        rState <= ARMED;
                    end
                end
                ARMED: begin
                    // The first qualified tick opens the measurement window.
                    if (qTick) begin
                        rCount <= ZERO;
                        rState <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (iEnable) begin
                        if (countFull) begin
                            // Saturated: the window is abandoned, so a re-arm
                            // needs a fresh tick.
                            rCount <= ZERO;
                            rState <= iContinuous ? ARMED : IDLE;
                        end else if (qTick) begin
                            // The capture tick doubles as the start of the next window.
                            rCount <= ZERO;
                            rState <= iContinuous ? MEASURE : IDLE;
                        end else begin
                            rCount <= rCount + ONE;
                        end
                    end
                end
                default: begin
                    rState <= IDLE;
                    rCount <= ZERO;
                end
            endcase
        end
    end

    // Result register and valid/ack/lost bookkeeping.
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            oPeriod   <= ZERO;
            oValid    <= 1'b0;
            oOverflow <= 1'b0;
            oLost     <= 1'b0;
        end else if (capture) begin
            oPeriod   <= overflowCapture ? ALL_ONES : (rCount + ONE);
            oOverflow <= overflowCapture;
            oLost     <= oValid && !iAck;
            oValid    <= 1'b1;
        end else if (iAck) begin
            oValid <= 1'b0;
            oLost  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: directed scenarios plus randomized traffic. A
// reference model built on enabled-cycle timestamps predicts the registered
// outputs after every clock edge; the driver pushes each prediction into a
// queue and an independent monitor pops and compares after the edge.
module tb_period_meter;

    localparam int W = 8;
    localparam int SNAP_W = W + 4;

    localparam int M_IDLE = 0;
    localparam int M_WAIT = 1;
    localparam int M_TIME = 2;

    logic iClk;
    logic iReset;
    logic iStart;
    logic iStop;
    logic iContinuous;
    logic iEnable;
    logic iTick;
    logic iAck;
    logic [W-1:0] oPeriod;
    logic oValid;
    logic oOverflow;
    logic oLost;
    logic oBusy;

    period_meter #(.WORDSIZE(W)) dut (
        .iClk        (iClk),
        .iReset      (iReset),
        .iStart      (iStart),
        .iStop       (iStop),
        .iContinuous (iContinuous),
        .iEnable     (iEnable),
        .iTick       (iTick),
        .iAck        (iAck),
        .oPeriod     (oPeriod),
        .oValid      (oValid),
        .oOverflow   (oOverflow),
        .oLost       (oLost),
        .oBusy       (oBusy)
    );

    // Clock and reset
    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    // Scoreboard state
    logic [SNAP_W-1:0] expQ[$];
    int checkCount = 0;
    int passCount = 0;

    // Reference model: tracks the enabled-cycle index of the tick that opened
    // the current window; a result is the distance between two such indices.
    int mMode = M_IDLE;
    int enIdx = 0;
    int armIdx = 0;
    int ePeriod = 0;
    bit eValid = 0;
    bit eOvf = 0;
    bit eLost = 0;

    task automatic modelStep(input bit rst, input bit st, input bit sp, input bit co,
                             input bit en, input bit tk, input bit ak);
        bit qt;
        bit cap;
        bit ovf;
        int elapsed;
        qt = tk && en;
        cap = 0;
        ovf = 0;
        elapsed = 0;
        if (rst) begin
            mMode = M_IDLE;
            ePeriod = 0;
            eValid = 0;
            eOvf = 0;
            eLost = 0;
        end else begin
            if (sp) begin
                mMode = M_IDLE;
            end else if (mMode == M_IDLE) begin
                if (st) mMode = M_WAIT;
            end else if (mMode == M_WAIT) begin
                if (qt) begin
                    armIdx = enIdx;
                    mMode = M_TIME;
                end
            end else if (en) begin
                elapsed = enIdx - armIdx;
                if (elapsed >= (1 << W)) begin
                    cap = 1;
                    ovf = 1;
                    mMode = co ? M_WAIT : M_IDLE;
                end else if (qt) begin
                    cap = 1;
                    armIdx = enIdx;
                    mMode = co ? M_TIME : M_IDLE;
                end
            end
            if (cap) begin
                ePeriod = ovf ? ((1 << W) - 1) : elapsed;
                eLost = eValid && !ak;
                eValid = 1;
                eOvf = ovf;
            end else if (ak) begin
                eValid = 0;
                eLost = 0;
            end
        end
        if (en) enIdx++;
    endtask

    function automatic logic [SNAP_W-1:0] snap();
        logic [W-1:0] p;
        p = ePeriod[W-1:0];
        return {p, eValid, eOvf, eLost, (mMode != M_IDLE)};
    endfunction

    // Driver: apply one cycle of inputs away from the active edge and record
    // the prediction for the following rising edge.
    task automatic step(input bit rst, input bit st, input bit sp, input bit co,
                        input bit en, input bit tk, input bit ak);
        @(negedge iClk);
        iReset = rst;
        iStart = st;
        iStop = sp;
        iContinuous = co;
        iEnable = en;
        iTick = tk;
        iAck = ak;
        modelStep(rst, st, sp, co, en, tk, ak);
        expQ.push_back(snap());
    endtask

    // gap-1 enabled cycles without a tick, then one enabled tick cycle.
    task automatic tickAfter(input int gap, input bit co, input bit ak);
        for (int c = 1; c <= gap; c++) begin
            step(0, 0, 0, co, 1, (c == gap), ak);
        end
    endtask

    task automatic startPulse(input bit co);
        step(0, 1, 0, co, 1, 0, 0);
    endtask

    task automatic stopAndClear();
        step(0, 0, 1, 0, 1, 0, 1);
        step(0, 0, 0, 0, 1, 0, 1);
    endtask

    // Monitor: compare DUT outputs after each rising edge with the queued prediction.
    initial begin
        logic [SNAP_W-1:0] exp;
        logic [SNAP_W-1:0] act;
        forever begin
            @(posedge iClk);
            #2;
            if (expQ.size() > 0) begin
                exp = expQ.pop_front();
                act = {oPeriod, oValid, oOverflow, oLost, oBusy};
                checkCount++;
                if (act === exp) begin
                    passCount++;
                end else begin
                    $display("FAIL outputs @%0t: got period=%0d valid=%b ovf=%b lost=%b busy=%b, expected period=%0d valid=%b ovf=%b lost=%b busy=%b",
                             $time, act[SNAP_W-1:4], act[3], act[2], act[1], act[0],
                             exp[SNAP_W-1:4], exp[3], exp[2], exp[1], exp[0]);
                end
            end
        end
    end

    // Stimulus
    initial begin
        int tickDen;
        bit co;
        iReset = 1'b1;
        iStart = 1'b0;
        iStop = 1'b0;
        iContinuous = 1'b0;
        iEnable = 1'b0;
        iTick = 1'b0;
        iAck = 1'b0;

        // Reset values
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 1, 0, 0);

        // Single shot, ticks every 5 cycles; later ticks ignored
        startPulse(0);
        for (int t = 0; t < 5; t++) tickAfter(5, 0, 0);
        stopAndClear();

        // iEnable toggling, aligned ticks every 8 raw cycles plus stray ticks on disabled cycles
        startPulse(0);
        for (int i = 1; i <= 40; i++) begin
            step(0, 0, 0, 0, (i % 2 == 0), ((i % 8 == 0) || (i % 8 == 3) || (i % 8 == 5)), 0);
        end
        stopAndClear();

        // Continuous period 3: lost result, ack clears, ack coincident with a capture
        startPulse(1);
        tickAfter(1, 1, 0);
        tickAfter(3, 1, 0);
        tickAfter(3, 1, 0);
        step(0, 0, 0, 1, 1, 0, 1);
        step(0, 0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 1, 1, 1, 0);
        step(0, 0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 1, 1, 1, 1);
        step(0, 0, 0, 1, 1, 0, 0);
        stopAndClear();

        // Largest reportable period, then saturation and re-arm in continuous mode
        startPulse(1);
        tickAfter(1, 1, 1);
        tickAfter((1 << W) - 1, 1, 0);
        tickAfter((1 << W), 1, 0);
        tickAfter(10, 1, 0);
        tickAfter(10, 1, 1);
        stopAndClear();

        // Saturation with no tick at all, single shot
        startPulse(0);
        tickAfter(1, 0, 0);
        for (int i = 0; i < (1 << W) + 4; i++) step(0, 0, 0, 0, 1, 0, 0);
        stopAndClear();

        // Period 1, continuous
        startPulse(1);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 1, 1, (i == 6));
        stopAndClear();

        // Asynchronous reset mid-measurement with a result pending
        startPulse(1);
        tickAfter(1, 1, 0);
        tickAfter(6, 1, 0);
        step(0, 0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 1, 1, 0, 0);
        @(negedge iClk);
        #2;
        iReset = 1'b1;
        #1;
        checkCount++;
        if ({oPeriod, oValid, oOverflow, oLost, oBusy} === {SNAP_W{1'b0}}) begin
            passCount++;
        end else begin
            $display("FAIL async_reset: got period=%0d valid=%b ovf=%b lost=%b busy=%b, expected all zero",
                     oPeriod, oValid, oOverflow, oLost, oBusy);
        end
        modelStep(1, 0, 0, 1, 1, 0, 0);
        expQ.push_back(snap());
        step(1, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);

        // Stop mid-measurement (with a coincident tick) keeps the pending result
        startPulse(0);
        tickAfter(1, 0, 0);
        step(0, 0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 1, 1, 0, 0);
        tickAfter(4, 1, 0);
        step(0, 0, 0, 1, 1, 0, 0);
        step(0, 0, 1, 1, 1, 1, 0);
        step(0, 0, 0, 1, 1, 1, 0);
        step(0, 0, 0, 1, 1, 1, 0);

        // Start and stop together in IDLE, and start ignored while busy
        step(0, 1, 1, 0, 1, 1, 0);
        step(0, 0, 0, 0, 1, 1, 0);
        startPulse(0);
        step(0, 1, 0, 0, 1, 0, 0);
        tickAfter(2, 0, 0);
        step(0, 1, 0, 0, 1, 0, 0);
        tickAfter(7, 0, 1);
        stopAndClear();

        // Randomized traffic in segments with different tick densities
        for (int seg = 0; seg < 10; seg++) begin
            case ($urandom_range(0, 3))
                0: tickDen = 2;
                1: tickDen = 5;
                2: tickDen = 20;
                default: tickDen = 400;
            endcase
            co = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 49) == 0) co = ~co;
                step(0,
                     ($urandom_range(0, 9) == 0),
                     ($urandom_range(0, 199) == 0),
                     co,
                     ($urandom_range(0, 3) != 0),
                     ($urandom_range(1, tickDen) == 1),
                     ($urandom_range(0, 5) == 0));
            end
        end

        // Drain and report
        step(0, 0, 1, 0, 1, 0, 1);
        @(negedge iClk);
        @(negedge iClk);
        checkCount++;
        if (expQ.size() == 0) begin
            passCount++;
        end else begin
            $display("FAIL drain: got %0d predictions left, expected 0", expQ.size());
        end
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
